serial_result_collector: RTL and testbench

- Receiving end of the serial adder datapath. Takes the LSB-first serial sum stream and the final carry, both qualified by the adder controller's LOAD/EN_OUT strobes.
- Assembles the stream into a parallel WIDTH-bit result plus carry-out.
- Presents the result to a downstream consumer over a VALID/RDY handshake and flags results that were lost before pickup.

---
 rtl/serial_result_collector_pkg.sv | 31 +++
 rtl/serial_result_collector_sipo_shift_reg.sv | 37 +++
 rtl/serial_result_collector.sv | 165 ++++++++++++++++
 tb/tb_serial_result_collector.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_result_collector_pkg.sv
// ---------------------------------------------------------------------------
// serial_result_collector_pkg
// Shared definitions for the serial adder datapath: the collector FSM state
// encoding and the default operand width used by the adder controller, the
// shift registers and the result collector.
// ---------------------------------------------------------------------------
package serial_result_collector_pkg;

  // Default number of sum bits per operation.
  localparam int DEFAULT_WIDTH = 8;

  // Collector FSM states, 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_COLLECT = 3'd2,
    ST_CARRY   = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  // True for the states in which an operation is in flight.
  function automatic logic state_is_busy(input state_t st);
    logic busy;
    case (st)
      ST_ARM, ST_COLLECT, ST_CARRY: busy = 1'b1;
      default:                      busy = 1'b0;
    endcase
    return busy;
  endfunction

endpackage

// File: rtl/serial_result_collector_sipo_shift_reg.sv
// ---------------------------------------------------------------------------
// sipo_shift_reg
// WIDTH-bit serial-in / parallel-out register. Bits enter at the MSB and move
// toward bit 0, so after WIDTH shifts bit 0 holds the first bit received.
// Ports:
//   CLK      rising-edge clock
//   RST      synchronous active-high reset (clears the register)
//   CLR      synchronous clear
//   SHIFT_EN shift SER_IN in this edge
//   SER_IN   serial data in
//   PAR_OUT  registered parallel contents
// ---------------------------------------------------------------------------
module sipo_shift_reg
  import serial_result_collector_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             SHIFT_EN,
  input  logic             SER_IN,
  output logic [WIDTH-1:0] PAR_OUT
);

  // Shift register with reset, clear (priority over shift) and shift enable.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PAR_OUT <= {WIDTH{1'b0}};
    end else if (CLR) begin
      PAR_OUT <= {WIDTH{1'b0}};
    end else if (SHIFT_EN) begin
      PAR_OUT <= {SER_IN, PAR_OUT[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/serial_result_collector.sv
// ---------------------------------------------------------------------------
// serial_result_collector
// Receiving end of the serial adder: assembles the LSB-first sum stream into
// a WIDTH-bit RESULT plus COUT and offers it downstream over VALID/RDY.
// OVERRUN is a sticky flag raised when a new operation is started while a
// result is still waiting for pickup.
// Ports:
//   CLK       rising-edge clock
//   RST       synchronous active-high reset
//   LOAD_IN   controller LOAD; arms or restarts collection
//   EN_IN     controller EN_OUT; with LOAD_IN=0 marks SUM_BIT valid
//   SUM_BIT   serial sum bit, LSB first
//   CARRY_IN  adder carry flip-flop output
//   RDY       downstream ready
//   RESULT    assembled sum (bit 0 = first bit received)
//   COUT      final carry-out
//   VALID     RESULT/COUT valid
//   BUSY      operation in flight (ARM, COLLECT, CARRY)
//   OVERRUN   sticky lost-result flag
// ---------------------------------------------------------------------------
module serial_result_collector
  import serial_result_collector_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD_IN,
  input  logic             EN_IN,
  input  logic             SUM_BIT,
  input  logic             CARRY_IN,
  input  logic             RDY,
  output logic [WIDTH-1:0] RESULT,
  output logic             COUT,
  output logic             VALID,
  output logic             BUSY,
  output logic             OVERRUN
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_t          state_r;
  logic [CW-1:0]   count_r;
  logic            cout_r;
  logic            valid_r;
  logic            busy_r;
  logic            overrun_r;
  logic            clr_s;
  logic            shift_s;
  logic [WIDTH-1:0] result_s;

  // Shift-register controls: clear on every entry into ARM, shift on a valid
  // beat in ARM or COLLECT (ARM's exit edge captures the first bit).
  always_comb begin
    clr_s   = 1'b0;
    shift_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        clr_s = LOAD_IN;
      end
      ST_ARM, ST_COLLECT: begin
        clr_s   = LOAD_IN;
        shift_s = !LOAD_IN && EN_IN;
      end
      ST_HOLD: begin
        // Only a completed handshake may move on to ARM.
        clr_s = LOAD_IN && RDY;
      end
      default: begin
        clr_s   = 1'b0;
        shift_s = 1'b0;
      end
    endcase
  end

  sipo_shift_reg #(
    .WIDTH (WIDTH)
  ) u_sipo (
    .CLK      (CLK),
    .RST      (RST),
    .CLR      (clr_s),
    .SHIFT_EN (shift_s),
    .SER_IN   (SUM_BIT),
    .PAR_OUT  (result_s)
  );

  // Collector FSM, bit counter, carry capture and handshake registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      count_r   <= {CW{1'b0}};
      cout_r    <= 1'b0;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (clr_s) begin
        count_r <= {CW{1'b0}};
      end else if (shift_s) begin
        count_r <= count_r + CW'(1'b1);
      end

      case (state_r)
        ST_IDLE: begin
          if (LOAD_IN) begin
            state_r <= ST_ARM;
            busy_r  <= state_is_busy(ST_ARM);
          end
        end
        ST_ARM: begin
          if (!LOAD_IN) begin
            if (EN_IN) begin
              state_r <= ST_COLLECT;
              busy_r  <= state_is_busy(ST_COLLECT);
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= state_is_busy(ST_IDLE);
            end
          end
        end
        ST_COLLECT: begin
          if (LOAD_IN) begin
            state_r <= ST_ARM;
          end else if (EN_IN && (count_r == LAST_CNT)) begin
            state_r <= ST_CARRY;
            busy_r  <= state_is_busy(ST_CARRY);
          end
        end
        ST_CARRY: begin
          cout_r  <= CARRY_IN;
          valid_r <= 1'b1;
          state_r <= ST_HOLD;
          busy_r  <= state_is_busy(ST_HOLD);
        end
        ST_HOLD: begin
          if (RDY) begin
            valid_r <= 1'b0;
            if (LOAD_IN) begin
              state_r <= ST_ARM;
              busy_r  <= state_is_busy(ST_ARM);
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= state_is_busy(ST_IDLE);
            end
          end else if (LOAD_IN) begin
            overrun_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign RESULT  = result_s;
  assign COUT    = cout_r;
  assign VALID   = valid_r;
  assign BUSY    = busy_r;
  assign OVERRUN = overrun_r;

endmodule

// File: tb/tb_serial_result_collector.sv
// ---------------------------------------------------------------------------
// tb_serial_result_collector
// Directed self-checking bench for serial_result_collector (WIDTH=8).
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_serial_result_collector;

  logic       CLK = 1'b0;
  logic       RST;
  logic       LOAD_IN;
  logic       EN_IN;
  logic       SUM_BIT;
  logic       CARRY_IN;
  logic       RDY;
  logic [7:0] RESULT;
  logic       COUT;
  logic       VALID;
  logic       BUSY;
  logic       OVERRUN;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  serial_result_collector #(
    .WIDTH (8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .LOAD_IN  (LOAD_IN),
    .EN_IN    (EN_IN),
    .SUM_BIT  (SUM_BIT),
    .CARRY_IN (CARRY_IN),
    .RDY      (RDY),
    .RESULT   (RESULT),
    .COUT     (COUT),
    .VALID    (VALID),
    .BUSY     (BUSY),
    .OVERRUN  (OVERRUN)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Shift bits [hi:lo] of val in LSB first.
  task automatic send_bits(input logic [7:0] val, input int lo, input int hi);
    LOAD_IN = 1'b0;
    EN_IN   = 1'b1;
    for (int i = lo; i <= hi; i++) begin
      SUM_BIT = val[i];
      step();
    end
  endtask

  // One LOAD cycle, 8 bits, then the CARRY cycle; ends with VALID expected 1.
  task automatic do_op(input logic [7:0] val, input logic carry);
    LOAD_IN = 1'b1;
    EN_IN   = 1'b0;
    step();
    send_bits(val, 0, 7);
    EN_IN    = 1'b0;
    SUM_BIT  = 1'b0;
    CARRY_IN = carry;
    step();
  endtask

  initial begin
    RST = 1'b1; LOAD_IN = 1'b0; EN_IN = 1'b0; SUM_BIT = 1'b0;
    CARRY_IN = 1'b0; RDY = 1'b0;
    step();
    step();
    RST = 1'b0;
    check_eq("rst_result",  RESULT,  32'h0);
    check_eq("rst_cout",    COUT,    32'h0);
    check_eq("rst_valid",   VALID,   32'h0);
    check_eq("rst_busy",    BUSY,    32'h0);
    check_eq("rst_overrun", OVERRUN, 32'h0);

    // Basic add 0x5A+0x3C = 0x96: bits 0,1,1,0,1,0,0,1.
    RDY = 1'b1;
    LOAD_IN = 1'b1;
    step();
    check_eq("basic_busy_arm", BUSY, 32'h1);
    step();
    step();
    send_bits(8'h96, 0, 7);
    check_eq("basic_valid_lat", VALID, 32'h0);
    check_eq("basic_busy_carry", BUSY, 32'h1);
    EN_IN = 1'b0; CARRY_IN = 1'b0;
    step();
    check_eq("basic_result", RESULT, 32'h96);
    check_eq("basic_cout",   COUT,   32'h0);
    check_eq("basic_valid",  VALID,  32'h1);
    check_eq("basic_busy",   BUSY,   32'h0);
    step();
    check_eq("basic_valid_1cyc", VALID, 32'h0);
    check_eq("basic_busy_after", BUSY,  32'h0);

    // Carry-out 0xFF+0x01: zero sum, carry 1; extra EN beats in CARRY/HOLD ignored.
    RDY = 1'b0;
    LOAD_IN = 1'b1;
    step();
    send_bits(8'h00, 0, 7);
    EN_IN = 1'b1; SUM_BIT = 1'b1; CARRY_IN = 1'b1;
    step();
    check_eq("carry_result", RESULT, 32'h00);
    check_eq("carry_cout",   COUT,   32'h1);
    check_eq("carry_valid",  VALID,  32'h1);
    // Backpressure: 5 cycles with RDY=0.
    CARRY_IN = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("bp_valid",  VALID,  32'h1);
      check_eq("bp_result", RESULT, 32'h00);
      check_eq("bp_cout",   COUT,   32'h1);
    end
    EN_IN = 1'b0; SUM_BIT = 1'b0;
    RDY = 1'b1;
    step();
    check_eq("bp_valid_drop", VALID, 32'h0);

    // Pause after bit 3 of 0xC3: partial 0x60 must hold for two idle beats.
    LOAD_IN = 1'b1;
    step();
    send_bits(8'hC3, 0, 2);
    EN_IN = 1'b0;
    step();
    step();
    check_eq("pause_result", RESULT, 32'h60);
    check_eq("pause_busy",   BUSY,   32'h1);
    send_bits(8'hC3, 3, 7);
    EN_IN = 1'b0; CARRY_IN = 1'b0; RDY = 1'b0;
    step();
    check_eq("pause_final", RESULT, 32'hC3);
    check_eq("pause_valid", VALID,  32'h1);
    RDY = 1'b1;
    step();

    // Abort after bit 5, then a full 0xA5 op with carry.
    LOAD_IN = 1'b1;
    step();
    send_bits(8'hFF, 0, 4);
    LOAD_IN = 1'b1; EN_IN = 1'b0;
    step();
    check_eq("abort_result", RESULT, 32'h00);
    check_eq("abort_valid",  VALID,  32'h0);
    check_eq("abort_busy",   BUSY,   32'h1);
    send_bits(8'hA5, 0, 7);
    check_eq("abort_no_early_valid", VALID, 32'h0);
    EN_IN = 1'b0; CARRY_IN = 1'b1; RDY = 1'b0;
    step();
    check_eq("abort_final", RESULT, 32'hA5);
    check_eq("abort_cout",  COUT,   32'h1);
    check_eq("abort_valid2", VALID, 32'h1);
    RDY = 1'b1;
    step();

    // Overrun: LOAD in HOLD with RDY=0.
    RDY = 1'b0;
    do_op(8'h3C, 1'b0);
    check_eq("ovr_pre_valid", VALID, 32'h1);
    LOAD_IN = 1'b1;
    step();
    check_eq("ovr_flag",   OVERRUN, 32'h1);
    check_eq("ovr_result", RESULT,  32'h3C);
    check_eq("ovr_valid",  VALID,   32'h1);
    check_eq("ovr_busy",   BUSY,    32'h0);
    LOAD_IN = 1'b0;
    step();
    check_eq("ovr_sticky", OVERRUN, 32'h1);
    check_eq("ovr_hold",   RESULT,  32'h3C);
    // LOAD together with RDY: handshake completes, straight to ARM.
    LOAD_IN = 1'b1; RDY = 1'b1;
    step();
    check_eq("sim_valid",   VALID,   32'h0);
    check_eq("sim_busy",    BUSY,    32'h1);
    check_eq("sim_overrun", OVERRUN, 32'h1);
    check_eq("sim_result",  RESULT,  32'h00);
    RDY = 1'b0;
    send_bits(8'h81, 0, 7);
    EN_IN = 1'b0; CARRY_IN = 1'b0;
    step();
    check_eq("sim_final", RESULT, 32'h81);
    check_eq("sim_valid2", VALID, 32'h1);
    RDY = 1'b1;
    step();

    // Reset mid-collection after bit 4.
    LOAD_IN = 1'b1;
    step();
    send_bits(8'hFF, 0, 3);
    RST = 1'b1; CARRY_IN = 1'b1;
    step();
    check_eq("mrst_result",  RESULT,  32'h0);
    check_eq("mrst_cout",    COUT,    32'h0);
    check_eq("mrst_valid",   VALID,   32'h0);
    check_eq("mrst_busy",    BUSY,    32'h0);
    check_eq("mrst_overrun", OVERRUN, 32'h0);
    RST = 1'b0; EN_IN = 1'b0; SUM_BIT = 1'b0; CARRY_IN = 1'b0;
    step();
    check_eq("mrst_idle_busy", BUSY, 32'h0);
    RDY = 1'b0;
    do_op(8'h5A, 1'b1);
    check_eq("post_rst_result", RESULT,  32'h5A);
    check_eq("post_rst_cout",   COUT,    32'h1);
    check_eq("post_rst_valid",  VALID,   32'h1);
    check_eq("post_rst_ovr",    OVERRUN, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
